// File: rtl/spi_sfr_pkg.sv
// Shared address map, register bit positions and reset values for the SPI SFR bank.
package spi_sfr_pkg;

  typedef enum logic [2:0] {
    A_CR1  = 3'd0,
    A_CR2  = 3'd1,
    A_BR   = 3'd2,
    A_SR   = 3'd3,
    A_DR   = 3'd4,
    A_IER  = 3'd5,
    A_RSV6 = 3'd6,
    A_RSV7 = 3'd7
  } sfr_addr_e;

  localparam int CR1_SPEN  = 0;
  localparam int CR1_MSTR  = 1;
  localparam int CR1_CPOL  = 2;
  localparam int CR1_CPHA  = 3;
  localparam int CR1_LSBFE = 4;

  localparam int CR2_TXFLUSH = 0;
  localparam int CR2_RXFLUSH = 1;

  localparam int SR_TXE   = 0;
  localparam int SR_TXF   = 1;
  localparam int SR_RXNE  = 2;
  localparam int SR_RXF   = 3;
  localparam int SR_BUSY  = 4;
  localparam int SR_TXOVR = 5;
  localparam int SR_RXOVR = 6;
  localparam int SR_RXUDR = 7;

  localparam logic [7:0] CR1_RST = 8'h00;
  localparam logic [7:0] IER_RST = 8'h00;

  // Field order matches the SR bit layout, so the struct packs straight onto SR[7:0].
  typedef struct packed {
    logic rxudr;
    logic rxovr;
    logic txovr;
    logic busy;
    logic rxf;
    logic rxne;
    logic txf;
    logic txe;
  } sr_t;

endpackage

// File: rtl/spi_sfr_fifo.sv
// Single-clock FIFO with wrap-bit pointers; pop on empty is ignored, push on full passes only with a same-cycle pop.
module spi_sfr_fifo #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]                       r_wptr, r_rptr;
  logic [FIFO_DEPTH-1:0][DW-1:0]     r_mem;
  logic                              w_do_push, w_do_pop;

  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty = (r_wptr == r_rptr);
  assign head  = r_mem[r_rptr[AW-1:0]];

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Flush overrides everything in the same cycle, including a pending push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_mem  <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= din;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_do_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/spi_sfr_bank.sv
// SFR bank for the SPI controller: control/baud/IER registers, live status with sticky W1C errors,
// TX/RX FIFOs behind DR, registered reads and a registered level interrupt.
module spi_sfr_bank
  import spi_sfr_pkg::*;
#(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sfr_we,
  input  logic [2:0]    sfr_waddr,
  input  logic [DW-1:0] sfr_wdata,
  input  logic          sfr_re,
  input  logic [2:0]    sfr_raddr,
  output logic [DW-1:0] sfr_rdata,
  output logic          sfr_rvalid,
  output logic          tx_valid,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ready,
  input  logic          rx_valid,
  input  logic [DW-1:0] rx_data,
  input  logic          spi_busy,
  output logic          spen,
  output logic          mstr,
  output logic          cpol,
  output logic          cpha,
  output logic          lsbfe,
  output logic [DW-1:0] baud_div,
  output logic          irq
);

  logic [7:0]    r_cr1, r_ier;
  logic [DW-1:0] r_br;
  logic          r_txovr, r_rxovr, r_rxudr;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid, r_irq;

  logic          w_wr_cr1, w_wr_cr2, w_wr_br, w_wr_sr, w_wr_dr, w_wr_ier, w_rd_dr;
  logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [DW-1:0] w_tx_head, w_rx_head;
  logic          w_tx_pop, w_rx_pop, w_tx_flush, w_rx_flush;
  logic          w_set_txovr, w_set_rxovr, w_set_rxudr;
  logic [7:0]    w_clr;
  sr_t           w_sr;
  logic [DW-1:0] w_rd_val;

  assign w_wr_cr1 = sfr_we && (sfr_waddr == A_CR1);
  assign w_wr_cr2 = sfr_we && (sfr_waddr == A_CR2);
  assign w_wr_br  = sfr_we && (sfr_waddr == A_BR);
  assign w_wr_sr  = sfr_we && (sfr_waddr == A_SR);
  assign w_wr_dr  = sfr_we && (sfr_waddr == A_DR);
  assign w_wr_ier = sfr_we && (sfr_waddr == A_IER);
  assign w_rd_dr  = sfr_re && (sfr_raddr == A_DR);

  assign w_tx_pop   = tx_ready & ~w_tx_empty;
  assign w_rx_pop   = w_rd_dr & ~w_rx_empty;
  assign w_tx_flush = w_wr_cr2 & sfr_wdata[CR2_TXFLUSH];
  assign w_rx_flush = w_wr_cr2 & sfr_wdata[CR2_RXFLUSH];

  // A push discarded by a same-cycle flush is not an overflow.
  assign w_set_txovr = w_wr_dr  & w_tx_full & ~w_tx_pop & ~w_tx_flush;
  assign w_set_rxovr = rx_valid & w_rx_full & ~w_rx_pop & ~w_rx_flush;
  assign w_set_rxudr = w_rd_dr  & w_rx_empty;
  assign w_clr       = w_wr_sr ? sfr_wdata[7:0] : 8'h00;

  spi_sfr_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(w_wr_dr), .pop(w_tx_pop), .flush(w_tx_flush),
    .din(sfr_wdata), .full(w_tx_full), .empty(w_tx_empty), .head(w_tx_head)
  );

  spi_sfr_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_valid), .pop(w_rx_pop), .flush(w_rx_flush),
    .din(rx_data), .full(w_rx_full), .empty(w_rx_empty), .head(w_rx_head)
  );

  always_comb begin
    w_sr       = '0;
    w_sr.txe   = w_tx_empty;
    w_sr.txf   = w_tx_full;
    w_sr.rxne  = ~w_rx_empty;
    w_sr.rxf   = w_rx_full;
    w_sr.busy  = spi_busy;
    w_sr.txovr = r_txovr;
    w_sr.rxovr = r_rxovr;
    w_sr.rxudr = r_rxudr;
  end

  // Reads sample pre-edge state, so a same-cycle write is seen only by later reads.
  always_comb begin
    w_rd_val = '0;
    case (sfr_raddr)
      A_CR1:   w_rd_val[7:0] = r_cr1;
      A_BR:    w_rd_val      = r_br;
      A_SR:    w_rd_val[7:0] = w_sr;
      A_DR:    if (!w_rx_empty) w_rd_val = w_rx_head;
      A_IER:   w_rd_val[7:0] = r_ier;
      default: w_rd_val      = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cr1    <= CR1_RST;
      r_ier    <= IER_RST;
      r_br     <= '0;
      r_txovr  <= 1'b0;
      r_rxovr  <= 1'b0;
      r_rxudr  <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_cr1) r_cr1 <= sfr_wdata[7:0];
      if (w_wr_br)  r_br  <= sfr_wdata;
      if (w_wr_ier) r_ier <= sfr_wdata[7:0];
      // Hardware set beats a same-cycle W1C.
      r_txovr  <= w_set_txovr | (r_txovr & ~w_clr[SR_TXOVR]);
      r_rxovr  <= w_set_rxovr | (r_rxovr & ~w_clr[SR_RXOVR]);
      r_rxudr  <= w_set_rxudr | (r_rxudr & ~w_clr[SR_RXUDR]);
      r_rvalid <= sfr_re;
      if (sfr_re) r_rdata <= w_rd_val;
      r_irq    <= |(w_sr & r_ier);
    end
  end

  assign sfr_rdata  = r_rdata;
  assign sfr_rvalid = r_rvalid;
  assign tx_valid   = ~w_tx_empty;
  assign tx_data    = w_tx_head;
  assign spen       = r_cr1[CR1_SPEN];
  assign mstr       = r_cr1[CR1_MSTR];
  assign cpol       = r_cr1[CR1_CPOL];
  assign cpha       = r_cr1[CR1_CPHA];
  assign lsbfe      = r_cr1[CR1_LSBFE];
  assign baud_div   = r_br;
  assign irq        = r_irq;

endmodule

// File: tb/tb_spi_sfr_bank.sv
// Directed plus random bench for spi_sfr_bank against a queue-based register/FIFO model.
module tb_spi_sfr_bank;

  localparam int DW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sfr_we = 1'b0, sfr_re = 1'b0;
  logic [2:0]    sfr_waddr = '0, sfr_raddr = '0;
  logic [DW-1:0] sfr_wdata = '0, rx_data = '0;
  logic          tx_ready = 1'b0, rx_valid = 1'b0, spi_busy = 1'b0;
  logic [DW-1:0] sfr_rdata, tx_data, baud_div;
  logic          sfr_rvalid, tx_valid, spen, mstr, cpol, cpha, lsbfe, irq;

  spi_sfr_bank #(.DW(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .sfr_we(sfr_we), .sfr_waddr(sfr_waddr), .sfr_wdata(sfr_wdata),
    .sfr_re(sfr_re), .sfr_raddr(sfr_raddr), .sfr_rdata(sfr_rdata), .sfr_rvalid(sfr_rvalid),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .spi_busy(spi_busy),
    .spen(spen), .mstr(mstr), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .baud_div(baud_div), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       m_txovr, m_rxovr, m_rxudr, m_irq;
  logic [7:0] m_cr1, m_br, m_ier, m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    txq.delete();
    rxq.delete();
    m_txovr = 0; m_rxovr = 0; m_rxudr = 0; m_irq = 0;
    m_cr1 = 0; m_br = 0; m_ier = 0; m_rdata = 0;
  endtask

  function automatic logic [7:0] m_sr(input logic busy);
    return {m_rxudr, m_rxovr, m_txovr, busy,
            rxq.size() == D, rxq.size() != 0, txq.size() == D, txq.size() == 0};
  endfunction

  // One clock: drive inputs, advance the model from the spec rules, tick, then compare.
  task automatic cyc(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                     input logic re, input logic [2:0] ra,
                     input logic txr, input logic rxv, input logic [7:0] rxd, input logic busy);
    logic [7:0] sr;
    logic       txpop, rxpop, txfl, rxfl, drw, drr, stx, srx, sud;
    int         tn, rn;
    sfr_we = we; sfr_waddr = wa; sfr_wdata = wd;
    sfr_re = re; sfr_raddr = ra;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd; spi_busy = busy;

    sr = m_sr(busy);
    tn = txq.size();
    rn = rxq.size();
    if (re) begin
      case (ra)
        3'd0:    m_rdata = m_cr1;
        3'd2:    m_rdata = m_br;
        3'd3:    m_rdata = sr;
        3'd4:    m_rdata = (rn > 0) ? rxq[0] : 8'h00;
        3'd5:    m_rdata = m_ier;
        default: m_rdata = 8'h00;
      endcase
    end
    m_irq = |(sr & m_ier);

    drw   = we && wa == 3'd4;
    drr   = re && ra == 3'd4;
    txfl  = we && wa == 3'd1 && wd[0];
    rxfl  = we && wa == 3'd1 && wd[1];
    txpop = txr && tn > 0;
    rxpop = drr && rn > 0;
    stx   = drw && tn == D && !txpop && !txfl;
    srx   = rxv && rn == D && !rxpop && !rxfl;
    sud   = drr && rn == 0;

    if (we && wa == 3'd3) begin
      if (wd[5]) m_txovr = 0;
      if (wd[6]) m_rxovr = 0;
      if (wd[7]) m_rxudr = 0;
    end
    if (stx) m_txovr = 1;
    if (srx) m_rxovr = 1;
    if (sud) m_rxudr = 1;

    if (txfl) txq.delete();
    else begin
      if (txpop) void'(txq.pop_front());
      if (drw && (tn < D || txpop)) txq.push_back(wd);
    end
    if (rxfl) rxq.delete();
    else begin
      if (rxpop) void'(rxq.pop_front());
      if (rxv && (rn < D || rxpop)) rxq.push_back(rxd);
    end

    if (we && wa == 3'd0) m_cr1 = wd;
    if (we && wa == 3'd2) m_br  = wd;
    if (we && wa == 3'd5) m_ier = wd;

    @(posedge clk);
    #1;
    chk("rvalid", sfr_rvalid, re);
    chk("rdata", sfr_rdata, m_rdata);
    chk("tx_valid", tx_valid, txq.size() != 0);
    if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
    chk("irq", irq, m_irq);
    chk("cr1_out", {lsbfe, cpha, cpol, mstr, spen}, m_cr1[4:0]);
    chk("baud_div", baud_div, m_br);

    sfr_we = 0; sfr_re = 0; tx_ready = 0; rx_valid = 0; spi_busy = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cyc(1, a, d, 0, 3'd0, 0, 0, 8'h00, 0);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(0, 3'd0, 8'h00, 1, a, 0, 0, 8'h00, 0);
  endtask

  initial begin
    m_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_rvalid", sfr_rvalid, 1'b0);
    chk("rst_rdata", sfr_rdata, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_txvalid", tx_valid, 1'b0);
    chk("rst_ctrl", {lsbfe, cpha, cpol, mstr, spen}, 5'b0);
    rst = 1'b1;

    rd(3'd3); chk("rst_sr", sfr_rdata, 8'h01);
    rd(3'd0); chk("rst_cr1", sfr_rdata, 8'h00);
    rd(3'd6); chk("rsv6", sfr_rdata, 8'h00);
    rd(3'd7); chk("rsv7", sfr_rdata, 8'h00);
    wr(3'd6, 8'hFF);
    rd(3'd6); chk("rsv6_wr", sfr_rdata, 8'h00);

    wr(3'd0, 8'h1B);
    wr(3'd2, 8'h05);
    rd(3'd0); chk("cr1_rd", sfr_rdata, 8'h1B);
    rd(3'd2); chk("br_rd", sfr_rdata, 8'h05);
    chk("cr1_bits", {lsbfe, cpha, cpol, mstr, spen}, 5'b11011);

    // Same-cycle read and write of CR1 returns the old value.
    cyc(1, 3'd0, 8'h07, 1, 3'd0, 0, 0, 8'h00, 0);
    chk("rw_same", sfr_rdata, 8'h1B);
    wr(3'd0, 8'h1B);

    for (int i = 0; i < 5; i++) wr(3'd4, 8'hA1 + 8'(i));
    rd(3'd3); chk("tx_full_sr", sfr_rdata, 8'h22);
    for (int i = 0; i < 4; i++) begin
      chk("tx_order", tx_data, 8'hA1 + 8'(i));
      cyc(0, 3'd0, 8'h00, 0, 3'd0, 1, 0, 8'h00, 0);
    end
    chk("tx_drained", tx_valid, 1'b0);
    wr(3'd3, 8'h20);
    rd(3'd3); chk("txovr_clr", sfr_rdata, 8'h01);

    wr(3'd5, 8'h40);
    for (int i = 0; i < 5; i++) cyc(0, 3'd0, 8'h00, 0, 3'd0, 0, 1, 8'h31 + 8'(i), 0);
    rd(3'd3); chk("rxovr_sr", sfr_rdata, 8'h4D);
    chk("rxovr_irq", irq, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rd(3'd4); chk("rx_order", sfr_rdata, 8'h31 + 8'(i));
    end
    rd(3'd4); chk("rx_udr_data", sfr_rdata, 8'h00);
    rd(3'd3); chk("rx_udr_sr", sfr_rdata, 8'hC1);
    wr(3'd3, 8'hE0);
    wr(3'd5, 8'h00);

    for (int i = 0; i < 4; i++) cyc(0, 3'd0, 8'h00, 0, 3'd0, 0, 1, 8'h51 + 8'(i), 0);
    cyc(0, 3'd0, 8'h00, 1, 3'd4, 0, 1, 8'h55, 0);
    chk("full_pp_data", sfr_rdata, 8'h51);
    rd(3'd3); chk("full_pp_sr", sfr_rdata, 8'h0D);
    for (int i = 0; i < 4; i++) begin
      rd(3'd4); chk("full_pp_order", sfr_rdata, 8'h52 + 8'(i));
    end

    for (int i = 0; i < 4; i++) cyc(0, 3'd0, 8'h00, 0, 3'd0, 0, 1, 8'h61 + 8'(i), 0);
    cyc(1, 3'd1, 8'h02, 0, 3'd0, 0, 1, 8'h65, 0);
    rd(3'd3); chk("rxflush_sr", sfr_rdata, 8'h01);
    rd(3'd1); chk("cr2_rd0", sfr_rdata, 8'h00);

    // Set wins over a same-cycle W1C.
    cyc(0, 3'd0, 8'h00, 1, 3'd4, 0, 0, 8'h00, 0);
    cyc(1, 3'd3, 8'h80, 1, 3'd4, 0, 0, 8'h00, 0);
    rd(3'd3); chk("set_wins", sfr_rdata, 8'h81);
    wr(3'd3, 8'hE0);

    wr(3'd4, 8'h71);
    wr(3'd4, 8'h72);
    wr(3'd0, 8'h1F);
    rst = 1'b0;
    #1;
    chk("async_txvalid", tx_valid, 1'b0);
    chk("async_spen", spen, 1'b0);
    @(posedge clk); #1;
    m_reset();
    chk("rst_mid_txvalid", tx_valid, 1'b0);
    rst = 1'b1;
    rd(3'd3); chk("rst_mid_sr", sfr_rdata, 8'h01);

    for (int i = 0; i < 600; i++) begin
      logic       we, re, txr, rxv, busy;
      logic [2:0] wa, ra;
      logic [7:0] wd;
      we   = ($urandom_range(0, 2) == 0);
      wa   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
      wd   = 8'($urandom);
      if (wa == 3'd1 && $urandom_range(0, 3) != 0) wd = 8'h00;
      re   = ($urandom_range(0, 2) == 0);
      ra   = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
      txr  = ($urandom_range(0, 3) == 0);
      rxv  = ($urandom_range(0, 2) == 0);
      busy = 1'($urandom);
      cyc(we, wa, wd, re, ra, txr, rxv, 8'($urandom), busy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
